// File: rtl/trap_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// trap_sequencer_pkg
//   Shared definitions for the trap/mret sequencer and anything else that
//   talks to the machine-mode CSR unit:
//     - CSR addresses (mstatus, mie, mtvec, mepc, mcause)
//     - mstatus bit positions (MIE, MPIE, MPP)
//     - CSR port op encodings
//     - exception / interrupt cause codes
//     - helpers for the mstatus trap-entry update and 4-byte alignment
// ----------------------------------------------------------------------------
package trap_sequencer_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // mstatus bit positions
    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_HI = 12;
    localparam int MS_MPP_LO = 11;

    // CSR port op encodings
    localparam logic [2:0] CSR_OP_NONE  = 3'b000;
    localparam logic [2:0] CSR_OP_WRITE = 3'b001;
    localparam logic [2:0] CSR_OP_SET   = 3'b010;
    localparam logic [2:0] CSR_OP_CLEAR = 3'b011;

    // Cause codes (mcause[30:0])
    localparam int CAUSE_BREAKPOINT     = 3;
    localparam int CAUSE_MISALIGNED_LD  = 4;
    localparam int CAUSE_MISALIGNED_ST  = 6;
    localparam int CAUSE_ECALL_M        = 11;
    localparam int CAUSE_M_EXT_IRQ      = 11;

    // Trap entry: MPP <- M-mode, MPIE <- MIE, MIE <- 0. Other bits kept.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r                      = ms;
        r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        r[MS_MPIE]             = ms[MS_MIE];
        r[MS_MIE]              = 1'b0;
        return r;
    endfunction

    // Drop the two low bits (mtvec mode field / misaligned mepc)
    function automatic logic [31:0] align4(input logic [31:0] v);
        return {v[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_sequencer.sv
// ----------------------------------------------------------------------------
// trap_sequencer
//   Drives the CSR unit port for machine-mode trap entry and mret, then
//   issues a one-cycle PC redirect with flush. While a sequence is running
//   the block owns the CSR port (csr_owner) and holds the pipeline (stall).
//
//   Trap : IDLE -> T_MS_RD (read mstatus) -> T_MS_WR (write updated mstatus)
//               -> T_TV_RD (read mtvec)   -> RDIR
//   mret : IDLE -> R_EP_RD (read mepc)    -> RDIR
//   mepc/mcause for sync traps and the mstatus restore for mret are done by
//   the CSR unit itself on the event cycle.
//
//   Optional feature, macro TRAP_SEQ_IRQ_EN: adds the level-sensitive
//   ext_irq input and the I_CHK / I_EP_WR / I_MC_WR states that take an
//   external interrupt when mstatus.MIE is set (with vectored mtvec support).
//
// Parameters
//   CSR_ADDR_W  CSR address width
//   IRQ_CAUSE   external-interrupt cause code (TRAP_SEQ_IRQ_EN only)
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   ecall, ebreak,
//   is_misaligned,
//   mret              single-cycle events from execute
//   ext_irq           external interrupt level (TRAP_SEQ_IRQ_EN only)
//   pc                PC of the instruction in execute
//   csr_r_en/w_en/op/
//   addr/wdata        CSR port request
//   csr_rdata         CSR read data, valid in the same cycle as csr_r_en
//   csr_owner         CSR port mux select (1 while a sequence runs)
//   stall             hold the pipeline
//   redirect_valid    one-cycle redirect strobe, redirect_pc its target
//   flush             flush younger instructions (same as redirect_valid)
// ----------------------------------------------------------------------------
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int CSR_ADDR_W = 12,
    parameter int IRQ_CAUSE  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ecall,
    input  logic                  ebreak,
    input  logic                  is_misaligned,
    input  logic                  mret,
`ifdef TRAP_SEQ_IRQ_EN
    input  logic                  ext_irq,
`endif
    input  logic [31:0]           pc,
    output logic                  csr_r_en,
    output logic                  csr_w_en,
    output logic [2:0]            csr_op,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    output logic [31:0]           csr_wdata,
    input  logic [31:0]           csr_rdata,
    output logic                  csr_owner,
    output logic                  stall,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic                  flush
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        T_MS_RD = 4'd1,
        T_MS_WR = 4'd2,
        T_TV_RD = 4'd3,
        R_EP_RD = 4'd4,
        RDIR    = 4'd5
`ifdef TRAP_SEQ_IRQ_EN
        ,
        I_CHK   = 4'd6,
        I_EP_WR = 4'd7,
        I_MC_WR = 4'd8
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] ms_q, ms_d;          // mstatus value read at trap entry
    logic [31:0] target_q, target_d;  // redirect target (mtvec or mepc)

    // All synchronous trap sources run the same CSR sequence; their
    // relative priority only matters for mcause, which the CSR unit writes.
    logic trap_evt;
    assign trap_evt = is_misaligned | ecall | ebreak;

`ifdef TRAP_SEQ_IRQ_EN
    logic        irq_q, irq_d;        // current sequence is an interrupt
    logic [31:0] epc_q, epc_d;        // pc captured when the interrupt is taken
`else
    // pc and IRQ_CAUSE are only needed by the interrupt path
    logic unused_cfg;
    assign unused_cfg = ^{pc, 32'(IRQ_CAUSE)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ms_q     <= '0;
            target_q <= '0;
`ifdef TRAP_SEQ_IRQ_EN
            irq_q    <= 1'b0;
            epc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ms_q     <= ms_d;
            target_q <= target_d;
`ifdef TRAP_SEQ_IRQ_EN
            irq_q    <= irq_d;
            epc_q    <= epc_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        ms_d           = ms_q;
        target_d       = target_q;
        csr_r_en       = 1'b0;
        csr_w_en       = 1'b0;
        csr_op         = CSR_OP_NONE;
        csr_addr       = '0;
        csr_wdata      = '0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
`ifdef TRAP_SEQ_IRQ_EN
        irq_d          = irq_q;
        epc_d          = epc_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (trap_evt) begin
                    stall   = 1'b1;
                    state_d = T_MS_RD;
                end else if (mret) begin
                    stall   = 1'b1;
                    state_d = R_EP_RD;
                end
`ifdef TRAP_SEQ_IRQ_EN
                // Interrupt check does not stall the event cycle; the stall
                // starts in I_CHK while mstatus.MIE is inspected.
                else if (ext_irq) begin
                    state_d = I_CHK;
                end
                irq_d = 1'b0;
`endif
            end

            T_MS_RD: begin
                stall    = 1'b1;
                csr_r_en = 1'b1;
                csr_addr = CSR_ADDR_W'(CSR_MSTATUS);
                ms_d     = csr_rdata;
                state_d  = T_MS_WR;
            end

            T_MS_WR: begin
                stall     = 1'b1;
                csr_w_en  = 1'b1;
                csr_op    = CSR_OP_WRITE;
                csr_addr  = CSR_ADDR_W'(CSR_MSTATUS);
                csr_wdata = trap_mstatus(ms_q);
                state_d   = T_TV_RD;
            end

            T_TV_RD: begin
                stall    = 1'b1;
                csr_r_en = 1'b1;
                csr_addr = CSR_ADDR_W'(CSR_MTVEC);
                target_d = align4(csr_rdata);
`ifdef TRAP_SEQ_IRQ_EN
                // Vectored mode: interrupts jump to base + 4*cause
                if (irq_q && csr_rdata[1:0] == 2'b01)
                    target_d = align4(csr_rdata) + (32'(IRQ_CAUSE) << 2);
`endif
                state_d  = RDIR;
            end

            R_EP_RD: begin
                stall    = 1'b1;
                csr_r_en = 1'b1;
                csr_addr = CSR_ADDR_W'(CSR_MEPC);
                target_d = align4(csr_rdata);
                state_d  = RDIR;
            end

            RDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                state_d        = IDLE;
`ifdef TRAP_SEQ_IRQ_EN
                irq_d          = 1'b0;
`endif
            end

`ifdef TRAP_SEQ_IRQ_EN
            I_CHK: begin
                stall    = 1'b1;
                csr_r_en = 1'b1;
                csr_addr = CSR_ADDR_W'(CSR_MSTATUS);
                if (csr_rdata[MS_MIE]) begin
                    ms_d    = csr_rdata;
                    epc_d   = pc;
                    irq_d   = 1'b1;
                    state_d = I_EP_WR;
                end else begin
                    state_d = IDLE;
                end
            end

            I_EP_WR: begin
                stall     = 1'b1;
                csr_w_en  = 1'b1;
                csr_op    = CSR_OP_WRITE;
                csr_addr  = CSR_ADDR_W'(CSR_MEPC);
                csr_wdata = epc_q;
                state_d   = I_MC_WR;
            end

            I_MC_WR: begin
                stall     = 1'b1;
                csr_w_en  = 1'b1;
                csr_op    = CSR_OP_WRITE;
                csr_addr  = CSR_ADDR_W'(CSR_MCAUSE);
                csr_wdata = {1'b1, 31'(IRQ_CAUSE)};
                // Rejoin the sync-trap path at the mstatus write
                state_d   = T_MS_WR;
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign flush     = redirect_valid;
    assign csr_owner = (state_q != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// ----------------------------------------------------------------------------
// tb_trap_sequencer
//   Self-checking bench for trap_sequencer. A small CSR unit model answers
//   reads combinationally; every expected CSR access and redirect is pushed
//   into a scoreboard queue when the event is driven and popped when the DUT
//   shows activity on the port. Interrupt scenarios compile only with
//   TRAP_SEQ_IRQ_EN defined.
// ----------------------------------------------------------------------------
module tb_trap_sequencer;

    localparam int CSR_ADDR_W = 12;
    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_DIR = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;   // CSR address, or redirect target for K_DIR
        logic [31:0] data;   // write data (K_WR only)
        int          cyc;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic                  ecall, ebreak, is_misaligned, mret;
`ifdef TRAP_SEQ_IRQ_EN
    logic                  ext_irq;
`endif
    logic [31:0]           pc;
    logic                  csr_r_en, csr_w_en;
    logic [2:0]            csr_op;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [31:0]           csr_wdata;
    logic [31:0]           csr_rdata;
    logic                  csr_owner, stall, redirect_valid, flush;
    logic [31:0]           redirect_pc;

    logic [31:0] m_mstatus, m_mtvec, m_mepc;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   stall_cnt, rv_cnt, w_cnt;

    trap_sequencer #(.CSR_ADDR_W(CSR_ADDR_W), .IRQ_CAUSE(11)) dut (
        .clk            (clk),
        .rst            (rst),
        .ecall          (ecall),
        .ebreak         (ebreak),
        .is_misaligned  (is_misaligned),
        .mret           (mret),
`ifdef TRAP_SEQ_IRQ_EN
        .ext_irq        (ext_irq),
`endif
        .pc             (pc),
        .csr_r_en       (csr_r_en),
        .csr_w_en       (csr_w_en),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_owner      (csr_owner),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // CSR unit read model
    always_comb begin
        csr_rdata = 32'h0;
        if (csr_r_en) begin
            case (csr_addr)
                12'h300: csr_rdata = m_mstatus;
                12'h305: csr_rdata = m_mtvec;
                12'h341: csr_rdata = m_mepc;
                default: csr_rdata = 32'h0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data, input int c);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        stall_cnt = 0;
        rv_cnt    = 0;
        w_cnt     = 0;
    endtask

    // Port monitor / scoreboard consumer
    always @(negedge clk) begin
        int   kind;
        exp_t e;
        if (!rst) begin
            if (stall)          stall_cnt++;
            if (redirect_valid) rv_cnt++;
            if (csr_w_en)       w_cnt++;
            check("rw_exclusive", 32'(csr_r_en & csr_w_en), 32'h0);
            check("flush_eq_redirect", 32'(flush), 32'(redirect_valid));
            if (!csr_r_en && !csr_w_en) begin
                check("idle_addr", 32'(csr_addr), 32'h0);
                check("idle_wdata", csr_wdata, 32'h0);
            end
            if (csr_w_en) check("write_op", 32'(csr_op), 32'h1);
            if (csr_r_en || csr_w_en || redirect_valid) begin
                kind = redirect_valid ? K_DIR : (csr_w_en ? K_WR : K_RD);
                if (sb.size() == 0) begin
                    check("unexpected_txn_kind", kind, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("txn_kind", kind, e.kind);
                    check("txn_cycle", cyc, e.cyc);
                    if (kind == K_DIR)
                        check("redirect_pc", redirect_pc, e.addr);
                    else
                        check("csr_addr", 32'(csr_addr), e.addr);
                    if (kind == K_WR)
                        check("csr_wdata", csr_wdata, e.data);
                end
            end
        end
    end

    initial begin
        int e0;
        cyc = 0; n_checks = 0; n_errors = 0;
        clear_counts();
        rst = 1'b1;
        ecall = 1'b0; ebreak = 1'b0; is_misaligned = 1'b0; mret = 1'b0;
`ifdef TRAP_SEQ_IRQ_EN
        ext_irq = 1'b0;
`endif
        pc = 32'h0;
        m_mstatus = 32'h0; m_mtvec = 32'h0; m_mepc = 32'h0;

        // Reset state
        step(2);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_owner", 32'(csr_owner), 32'h0);
        check("rst_redirect", 32'(redirect_valid), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_r_en", 32'(csr_r_en), 32'h0);
        check("rst_w_en", 32'(csr_w_en), 32'h0);
        check("rst_addr", 32'(csr_addr), 32'h0);
        check("rst_wdata", csr_wdata, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        rst = 1'b0;
        step(2);

        // ecall, mstatus=0x8, mtvec=0x100
        m_mstatus = 32'h8; m_mtvec = 32'h100; pc = 32'h1234;
        clear_counts();
        e0 = cyc;
        push(K_RD,  32'h300, 32'h0,    e0 + 1);
        push(K_WR,  32'h300, 32'h1880, e0 + 2);
        push(K_RD,  32'h305, 32'h0,    e0 + 3);
        push(K_DIR, 32'h100, 32'h0,    e0 + 4);
        ecall = 1'b1;
        #1 check("ecall_stall_evt", 32'(stall), 32'h1);
        step(1);
        ecall = 1'b0;
        step(6);
        check("ecall_stall_cycles", stall_cnt, 4);
        check("ecall_redirects", rv_cnt, 1);
        check("ecall_sb_drained", sb.size(), 0);

        // Reset while the mstatus write is on the port
        clear_counts();
        e0 = cyc;
        push(K_RD, 32'h300, 32'h0,    e0 + 1);
        push(K_WR, 32'h300, 32'h1880, e0 + 2);
        ecall = 1'b1;
        step(1);
        ecall = 1'b0;
        step(1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_stall", 32'(stall), 32'h0);
        check("midrst_owner", 32'(csr_owner), 32'h0);
        check("midrst_redirect", 32'(redirect_valid), 32'h0);
        check("midrst_w_en", 32'(csr_w_en), 32'h0);
        step(2);
        rst = 1'b0;
        step(6);
        check("midrst_no_redirect", rv_cnt, 0);
        check("midrst_sb_drained", sb.size(), 0);

        // mret, mepc=0x2003
        m_mepc = 32'h2003;
        clear_counts();
        e0 = cyc;
        push(K_RD,  32'h341,  32'h0, e0 + 1);
        push(K_DIR, 32'h2000, 32'h0, e0 + 2);
        mret = 1'b1;
        #1 check("mret_stall_evt", 32'(stall), 32'h1);
        step(1);
        mret = 1'b0;
        step(5);
        check("mret_no_writes", w_cnt, 0);
        check("mret_stall_cycles", stall_cnt, 2);
        check("mret_sb_drained", sb.size(), 0);

        // ecall + misaligned together, mret arrives mid-sequence
        m_mstatus = 32'h2; m_mtvec = 32'h403;
        clear_counts();
        e0 = cyc;
        push(K_RD,  32'h300, 32'h0,    e0 + 1);
        push(K_WR,  32'h300, 32'h1802, e0 + 2);
        push(K_RD,  32'h305, 32'h0,    e0 + 3);
        push(K_DIR, 32'h400, 32'h0,    e0 + 4);
        ecall = 1'b1; is_misaligned = 1'b1;
        step(1);
        ecall = 1'b0; is_misaligned = 1'b0;
        step(1);
        mret = 1'b1;
        step(1);
        mret = 1'b0;
        step(6);
        check("combo_redirects", rv_cnt, 1);
        check("combo_sb_drained", sb.size(), 0);

        // ebreak with all-ones mstatus/mtvec
        m_mstatus = 32'hFFFF_FFFF; m_mtvec = 32'hFFFF_FFFD;
        clear_counts();
        e0 = cyc;
        push(K_RD,  32'h300,       32'h0,         e0 + 1);
        push(K_WR,  32'h300,       32'hFFFF_FFF7, e0 + 2);
        push(K_RD,  32'h305,       32'h0,         e0 + 3);
        push(K_DIR, 32'hFFFF_FFFC, 32'h0,         e0 + 4);
        ebreak = 1'b1;
        step(1);
        ebreak = 1'b0;
        step(6);
        check("ebreak_sb_drained", sb.size(), 0);

`ifdef TRAP_SEQ_IRQ_EN
        // Interrupt with MIE clear: one stall cycle, no write
        m_mstatus = 32'h0;
        clear_counts();
        e0 = cyc;
        push(K_RD, 32'h300, 32'h0, e0 + 1);
        ext_irq = 1'b1;
        #1 check("irq_no_evt_stall", 32'(stall), 32'h0);
        step(1);
        ext_irq = 1'b0;
        step(4);
        check("irq_off_stall_cycles", stall_cnt, 1);
        check("irq_off_no_writes", w_cnt, 0);
        check("irq_off_sb_drained", sb.size(), 0);

        // Interrupt taken, vectored mtvec
        m_mstatus = 32'h8; m_mtvec = 32'h201; pc = 32'h40;
        clear_counts();
        e0 = cyc;
        push(K_RD,  32'h300, 32'h0,         e0 + 1);
        push(K_WR,  32'h341, 32'h40,        e0 + 2);
        push(K_WR,  32'h342, 32'h8000_000B, e0 + 3);
        push(K_WR,  32'h300, 32'h1880,      e0 + 4);
        push(K_RD,  32'h305, 32'h0,         e0 + 5);
        push(K_DIR, 32'h22C, 32'h0,         e0 + 6);
        ext_irq = 1'b1;
        step(1);
        ext_irq = 1'b0;
        step(8);
        check("irq_redirects", rv_cnt, 1);
        check("irq_sb_drained", sb.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
